mario_sprite_renderer: RTL

- Per-pixel renderer that sits between the VGA pixel scan and the Mario sprite ROM.
- Converts screen draw coordinates into 4-bit sprite-local X/Y addresses and drives them to the ROM.
- Consumes the ROM's 2-bit palette index and emits a 12-bit RGB pixel plus an opaque flag for the frame compositor.
- Handles 2^SCALE_SHIFT pixel scaling, horizontal flip, frame-synchronous position latching and invincibility flashing.

---
 rtl/mario_sprite_renderer.sv | 108 ++++++++++
 1 files changed

// File: rtl/mario_sprite_renderer.sv
// Two-stage pixel renderer for the Mario sprite: maps screen coordinates to ROM texel
// addresses, then turns the returned palette index into an RGB pixel with an opaque flag.
module mario_sprite_renderer #(
    parameter int          SPRITE_SIZE  = 16,
    parameter int          SCALE_SHIFT  = 1,
    parameter logic [11:0] COLOR_RED    = 12'hF00,
    parameter logic [11:0] COLOR_DARK   = 12'h630,
    parameter logic [11:0] COLOR_LIGHT  = 12'hFA6,
    parameter int          FLASH_PERIOD = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  drawX,
    input  logic [9:0]  drawY,
    input  logic [9:0]  mario_x,
    input  logic [9:0]  mario_y,
    input  logic        facing_left,
    input  logic        flash_en,
    output logic [3:0]  rom_x,
    output logic [3:0]  rom_y,
    input  logic [1:0]  rom_pal,
    output logic        pix_out_valid,
    output logic        sprite_on,
    output logic [11:0] sprite_rgb
);

    localparam int CNT_W = (FLASH_PERIOD > 2) ? $clog2(FLASH_PERIOD) : 1;
    localparam logic signed [10:0] BOX_S      = 11'(SPRITE_SIZE << SCALE_SHIFT);
    localparam logic [CNT_W-1:0]   FLASH_HALF = CNT_W'(FLASH_PERIOD / 2);
    localparam logic [CNT_W-1:0]   FLASH_LAST = CNT_W'(FLASH_PERIOD - 1);

    function automatic logic [11:0] f_palette(input logic [1:0] pal);
        case (pal)
            2'b01:   return COLOR_RED;
            2'b10:   return COLOR_DARK;
            2'b11:   return COLOR_LIGHT;
            default: return 12'h000;
        endcase
    endfunction

    logic [9:0]       r_shadow_x;
    logic [9:0]       r_shadow_y;
    logic             r_shadow_face;
    logic [CNT_W-1:0] r_flash_cnt;
    logic             r_valid_p1;
    logic             r_hit_p1;

    logic signed [10:0] w_dx_p0;
    logic signed [10:0] w_dy_p0;
    logic               w_hit_p0;
    logic [3:0]         w_tx_raw_p0;
    logic [3:0]         w_tx_p0;
    logic [3:0]         w_ty_p0;
    logic               w_visible;
    logic               w_on_p1;

    // Hit test runs against the frame-latched shadow position, never the live inputs.
    assign w_dx_p0     = $signed({1'b0, drawX}) - $signed({1'b0, r_shadow_x});
    assign w_dy_p0     = $signed({1'b0, drawY}) - $signed({1'b0, r_shadow_y});
    assign w_hit_p0    = pix_valid && !w_dx_p0[10] && (w_dx_p0 < BOX_S)
                                   && !w_dy_p0[10] && (w_dy_p0 < BOX_S);
    assign w_tx_raw_p0 = 4'(w_dx_p0 >>> SCALE_SHIFT);
    assign w_ty_p0     = 4'(w_dy_p0 >>> SCALE_SHIFT);
    assign w_tx_p0     = r_shadow_face ? (4'd15 - w_tx_raw_p0) : w_tx_raw_p0;

    assign w_visible   = !flash_en || (r_flash_cnt < FLASH_HALF);
    assign w_on_p1     = r_valid_p1 && r_hit_p1 && (rom_pal != 2'b00) && w_visible;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_shadow_x    <= '0;
            r_shadow_y    <= '0;
            r_shadow_face <= 1'b0;
            r_flash_cnt   <= '0;
            r_valid_p1    <= 1'b0;
            r_hit_p1      <= 1'b0;
            rom_x         <= '0;
            rom_y         <= '0;
            pix_out_valid <= 1'b0;
            sprite_on     <= 1'b0;
            sprite_rgb    <= '0;
        end else begin
            if (frame_start) begin
                r_shadow_x    <= mario_x;
                r_shadow_y    <= mario_y;
                r_shadow_face <= facing_left;
            end
            if (!flash_en)
                r_flash_cnt <= '0;
            else if (frame_start)
                r_flash_cnt <= (r_flash_cnt == FLASH_LAST) ? '0 : r_flash_cnt + 1'b1;

            // stage 1: texel address to the ROM
            r_valid_p1 <= pix_valid;
            r_hit_p1   <= w_hit_p0;
            rom_x      <= w_hit_p0 ? w_tx_p0 : 4'd0;
            rom_y      <= w_hit_p0 ? w_ty_p0 : 4'd0;

            // stage 2: palette lookup and visibility
            pix_out_valid <= r_valid_p1;
            sprite_on     <= w_on_p1;
            sprite_rgb    <= w_on_p1 ? f_palette(rom_pal) : 12'h000;
        end
    end

endmodule
